// File: rtl/timer_pkg.sv
// Shared SFR addresses, TCON/TMOD bit positions and timer mode encodings for the 8051 timer block.
package timer_pkg;

    localparam logic [7:0] ADDR_TCON = 8'h88;
    localparam logic [7:0] ADDR_TMOD = 8'h89;
    localparam logic [7:0] ADDR_TL0  = 8'h8A;
    localparam logic [7:0] ADDR_TL1  = 8'h8B;
    localparam logic [7:0] ADDR_TH0  = 8'h8C;
    localparam logic [7:0] ADDR_TH1  = 8'h8D;

    localparam int TCON_TF1 = 7;
    localparam int TCON_TR1 = 6;
    localparam int TCON_TF0 = 5;
    localparam int TCON_TR0 = 4;

    localparam int TMOD_GATE1 = 7;
    localparam int TMOD_CT1   = 6;
    localparam int TMOD_GATE0 = 3;
    localparam int TMOD_CT0   = 2;

    typedef enum logic [1:0] {
        MODE_13BIT  = 2'd0,
        MODE_16BIT  = 2'd1,
        MODE_RELOAD = 2'd2,
        MODE_SPLIT  = 2'd3
    } tmode_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// SFR bus between the datapath (master) and the timer block (slave); read data is combinational.
interface timer_ctrl_if;
    logic [7:0] sfr_addr;
    logic       sfr_we;
    logic [7:0] sfr_wdata;
    logic [7:0] sfr_rdata;
    logic       sfr_hit;

    modport master (output sfr_addr, sfr_we, sfr_wdata, input sfr_rdata, sfr_hit);
    modport slave  (input sfr_addr, sfr_we, sfr_wdata, output sfr_rdata, sfr_hit);
endinterface

// File: rtl/timer_core.sv
// One timer's TH/TL count registers: mode sequencing, overflow pulse (same clock as the wrap), SFR write priority.
// Single-cycle update; no backpressure, an SFR write on an increment clock wins over the increment.
module timer_core
    import timer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  tmode_e     mode_i,
    input  logic       split_i,
    input  logic       inc_i,
    input  logic       inc_hi_i,
    input  logic       we_tl_i,
    input  logic       we_th_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] tl_o,
    output logic [7:0] th_o,
    output logic       ovf_o,
    output logic       ovf_hi_o
);

    logic [7:0] tl_q, tl_d;
    logic [7:0] th_q, th_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            tl_q <= 8'h00;
            th_q <= 8'h00;
        end else begin
            tl_q <= tl_d;
            th_q <= th_d;
        end
    end

    always_comb begin
        tl_d     = tl_q;
        th_d     = th_q;
        ovf_o    = 1'b0;
        ovf_hi_o = 1'b0;
        if (split_i) begin
            if (inc_i) begin
                tl_d  = tl_q + 8'd1;
                ovf_o = (tl_q == 8'hFF);
            end
            if (inc_hi_i) begin
                th_d     = th_q + 8'd1;
                ovf_hi_o = (th_q == 8'hFF);
            end
        end else if (inc_i) begin
            case (mode_i)
                MODE_13BIT: begin
                    tl_d[4:0] = tl_q[4:0] + 5'd1;
                    if (tl_q[4:0] == 5'h1F) begin
                        th_d  = th_q + 8'd1;
                        ovf_o = (th_q == 8'hFF);
                    end
                end
                MODE_RELOAD: begin
                    if (tl_q == 8'hFF) begin
                        tl_d  = th_q;
                        ovf_o = 1'b1;
                    end else begin
                        tl_d = tl_q + 8'd1;
                    end
                end
                MODE_16BIT, MODE_SPLIT: begin
                    tl_d = tl_q + 8'd1;
                    if (tl_q == 8'hFF) begin
                        th_d  = th_q + 8'd1;
                        ovf_o = (th_q == 8'hFF);
                    end
                end
                default: ;
            endcase
        end

        // A TL write cancels this clock's increment and, in the chained modes, its carry into TH.
        if (we_tl_i) begin
            tl_d  = wdata_i;
            ovf_o = 1'b0;
            if (!split_i) begin
                th_d = th_q;
            end
        end
        if (we_th_i) begin
            th_d = wdata_i;
            if (split_i) begin
                ovf_hi_o = 1'b0;
            end else if (mode_i != MODE_RELOAD) begin
                ovf_o = 1'b0;
            end
        end
    end

    assign tl_o = tl_q;
    assign th_o = th_q;

endmodule

// File: rtl/timer_ctrl.sv
// 8051 Timer0/Timer1: TMOD/TCON, machine-cycle prescaler, pin synchronisers, SFR read mux. Optional TIMER_MODE3_EN splits T0 in mode 3.
// Register writes and flag updates take one clock; pin edges are seen SYNC_STAGES+1 clocks late; the SFR bus never stalls.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESCALE    = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    timer_ctrl_if.slave  sfr,
    input  logic         t0_pin,
    input  logic         t1_pin,
    input  logic         int0_n,
    input  logic         int1_n,
    input  logic         tf0_ack,
    input  logic         tf1_ack,
    output logic         irq_tf0,
    output logic         irq_tf1
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic [7:0]      tmod_q, tmod_d;
    logic [7:0]      tcon_q, tcon_d;
    logic [3:0]      sync_q [SYNC_STAGES];
    logic [1:0]      tpin_last_q, tpin_last_d;

    logic       tick;
    logic [3:0] pins_s;
    logic [1:0] t_fall;
    logic       we_tcon, we_tmod, we_tl0, we_tl1, we_th0, we_th1;
    tmode_e     mode0, mode1;
    logic       run0, run1, inc0, inc1, inc0_hi, split0;
    logic [7:0] tl0, th0, tl1, th1;
    logic       ovf0, ovf0_hi, ovf1, ovf1_hi, tf1_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q        <= '0;
            tmod_q      <= 8'h00;
            tcon_q      <= 8'h00;
            tpin_last_q <= 2'b11;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'hF;
            end
        end else begin
            ps_q        <= ps_d;
            tmod_q      <= tmod_d;
            tcon_q      <= tcon_d;
            tpin_last_q <= tpin_last_d;
            sync_q[0]   <= {int1_n, int0_n, t1_pin, t0_pin};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign tick = (ps_q == PS_W'(PRESCALE - 1));
    assign ps_d = tick ? '0 : ps_q + 1'b1;

    // External pins are sampled once per machine cycle, like the original part.
    assign pins_s      = sync_q[SYNC_STAGES-1];
    assign tpin_last_d = tick ? pins_s[1:0] : tpin_last_q;
    assign t_fall      = {2{tick}} & tpin_last_q & ~pins_s[1:0];

    assign we_tcon = sfr.sfr_we && (sfr.sfr_addr == ADDR_TCON);
    assign we_tmod = sfr.sfr_we && (sfr.sfr_addr == ADDR_TMOD);
    assign we_tl0  = sfr.sfr_we && (sfr.sfr_addr == ADDR_TL0);
    assign we_tl1  = sfr.sfr_we && (sfr.sfr_addr == ADDR_TL1);
    assign we_th0  = sfr.sfr_we && (sfr.sfr_addr == ADDR_TH0);
    assign we_th1  = sfr.sfr_we && (sfr.sfr_addr == ADDR_TH1);

    assign mode0 = tmode_e'(tmod_q[1:0]);
    assign mode1 = tmode_e'(tmod_q[5:4]);
    assign run0  = tcon_q[TCON_TR0] & (~tmod_q[TMOD_GATE0] | pins_s[2]);
    assign run1  = tcon_q[TCON_TR1] & (~tmod_q[TMOD_GATE1] | pins_s[3]);
    assign inc0  = run0 & (tmod_q[TMOD_CT0] ? t_fall[0] : tick);
    assign inc1  = run1 & (tmod_q[TMOD_CT1] ? t_fall[1] : tick) & (mode1 != MODE_SPLIT);

`ifdef TIMER_MODE3_EN
    assign split0 = (mode0 == MODE_SPLIT);
`else
    assign split0 = 1'b0;
`endif
    // In split mode TH0 borrows TR1 as its run bit and always counts machine cycles.
    assign inc0_hi = split0 & tcon_q[TCON_TR1] & tick;

    timer_core u_t0 (
        .clock    (clock),
        .reset    (reset),
        .mode_i   (mode0),
        .split_i  (split0),
        .inc_i    (inc0),
        .inc_hi_i (inc0_hi),
        .we_tl_i  (we_tl0),
        .we_th_i  (we_th0),
        .wdata_i  (sfr.sfr_wdata),
        .tl_o     (tl0),
        .th_o     (th0),
        .ovf_o    (ovf0),
        .ovf_hi_o (ovf0_hi)
    );

    timer_core u_t1 (
        .clock    (clock),
        .reset    (reset),
        .mode_i   (mode1),
        .split_i  (1'b0),
        .inc_i    (inc1),
        .inc_hi_i (1'b0),
        .we_tl_i  (we_tl1),
        .we_th_i  (we_th1),
        .wdata_i  (sfr.sfr_wdata),
        .tl_o     (tl1),
        .th_o     (th1),
        .ovf_o    (ovf1),
        .ovf_hi_o (ovf1_hi)
    );

    // T1 never splits, so its hi overflow is constant low; while T0 is split TH0 owns TF1.
    assign tf1_set = split0 ? ovf0_hi : (ovf1 | ovf1_hi);

    always_comb begin
        tmod_d = we_tmod ? sfr.sfr_wdata : tmod_q;
        tcon_d = we_tcon ? sfr.sfr_wdata : tcon_q;
        if (tf0_ack && !we_tcon) begin
            tcon_d[TCON_TF0] = 1'b0;
        end
        if (tf1_ack && !we_tcon) begin
            tcon_d[TCON_TF1] = 1'b0;
        end
        if (ovf0) begin
            tcon_d[TCON_TF0] = 1'b1;
        end
        if (tf1_set) begin
            tcon_d[TCON_TF1] = 1'b1;
        end
    end

    always_comb begin
        sfr.sfr_rdata = 8'h00;
        sfr.sfr_hit   = 1'b1;
        case (sfr.sfr_addr)
            ADDR_TCON: sfr.sfr_rdata = tcon_q;
            ADDR_TMOD: sfr.sfr_rdata = tmod_q;
            ADDR_TL0:  sfr.sfr_rdata = tl0;
            ADDR_TL1:  sfr.sfr_rdata = tl1;
            ADDR_TH0:  sfr.sfr_rdata = th0;
            ADDR_TH1:  sfr.sfr_rdata = th1;
            default:   sfr.sfr_hit   = 1'b0;
        endcase
    end

    assign irq_tf0 = tcon_q[TCON_TF0];
    assign irq_tf1 = tcon_q[TCON_TF1];

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized SFR traffic against a count-level reference model.
module tb_timer_ctrl;

    localparam int PS = 12;
`ifdef TIMER_MODE3_EN
    localparam bit MODE3 = 1'b1;
`else
    localparam bit MODE3 = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic t0_pin = 1'b1, t1_pin = 1'b1, int0_n = 1'b1, int1_n = 1'b1;
    logic tf0_ack = 1'b0, tf1_ack = 1'b0;
    logic irq_tf0, irq_tf1;

    timer_ctrl_if sfr_bus();

    timer_ctrl #(.PRESCALE(PS), .SYNC_STAGES(2)) dut (
        .clock   (clock),
        .reset   (reset),
        .sfr     (sfr_bus),
        .t0_pin  (t0_pin),
        .t1_pin  (t1_pin),
        .int0_n  (int0_n),
        .int1_n  (int1_n),
        .tf0_ack (tf0_ack),
        .tf1_ack (tf1_ack),
        .irq_tf0 (irq_tf0),
        .irq_tf1 (irq_tf1)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counters as plain integers, valid while C/T bits are 0 and /INTx pins are steady.
    typedef struct {int th; int tl; bit ovf;} cnt_t;
    logic [7:0] m_tmod, m_tcon;
    int m_th [2];
    int m_tl [2];
    int m_ps = 0;

    function automatic cnt_t bump(cnt_t c, int mode);
        cnt_t r;
        int v;
        r = c;
        r.ovf = 1'b0;
        case (mode)
            0: begin
                v = c.th * 32 + (c.tl % 32) + 1;
                if (v == 8192) begin v = 0; r.ovf = 1'b1; end
                r.th = v / 32;
                r.tl = (c.tl / 32) * 32 + v % 32;
            end
            2: begin
                if (c.tl == 255) begin r.tl = c.th; r.ovf = 1'b1; end
                else r.tl = c.tl + 1;
            end
            default: begin
                v = c.th * 256 + c.tl + 1;
                if (v == 65536) begin v = 0; r.ovf = 1'b1; end
                r.th = v / 256;
                r.tl = v % 256;
            end
        endcase
        return r;
    endfunction

    task automatic model_update();
        bit tick, split, en0, en1, ovfh, tf1_set;
        int wa, md0, md1;
        logic [7:0] wd, ncon;
        cnt_t c0, n0, c1, n1;
        tick = (m_ps == PS - 1);
        if (reset) begin
            m_tmod = 8'h00; m_tcon = 8'h00; m_ps = 0;
            m_th[0] = 0; m_th[1] = 0; m_tl[0] = 0; m_tl[1] = 0;
            return;
        end
        m_ps = (m_ps + 1) % PS;
        wa = sfr_bus.sfr_we ? int'(sfr_bus.sfr_addr) : -1;
        wd = sfr_bus.sfr_wdata;
        md0 = int'(m_tmod[1:0]);
        md1 = int'(m_tmod[5:4]);
        en0 = tick && m_tcon[4] && (!m_tmod[3] || int0_n);
        en1 = tick && m_tcon[6] && (!m_tmod[7] || int1_n);
        split = MODE3 && (md0 == 3);
        c0.th = m_th[0]; c0.tl = m_tl[0]; c0.ovf = 1'b0;
        c1.th = m_th[1]; c1.tl = m_tl[1]; c1.ovf = 1'b0;
        n0 = c0; n1 = c1; ovfh = 1'b0;
        if (split) begin
            if (en0) begin n0.tl = (c0.tl + 1) % 256; n0.ovf = (c0.tl == 255); end
            if (tick && m_tcon[6]) begin n0.th = (c0.th + 1) % 256; ovfh = (c0.th == 255); end
        end else if (en0) begin
            n0 = bump(c0, (md0 == 3) ? 1 : md0);
        end
        if (en1 && md1 != 3) n1 = bump(c1, md1);
        if (wa == 'h8A) begin n0.tl = int'(wd); n0.ovf = 1'b0; if (!split && md0 != 2) n0.th = c0.th; end
        if (wa == 'h8C) begin n0.th = int'(wd); if (split) ovfh = 1'b0; else if (md0 != 2) n0.ovf = 1'b0; end
        if (wa == 'h8B) begin n1.tl = int'(wd); n1.ovf = 1'b0; if (md1 != 2) n1.th = c1.th; end
        if (wa == 'h8D) begin n1.th = int'(wd); if (md1 != 2) n1.ovf = 1'b0; end
        tf1_set = split ? ovfh : n1.ovf;
        ncon = (wa == 'h88) ? wd : m_tcon;
        if (wa != 'h88 && tf0_ack) ncon[5] = 1'b0;
        if (wa != 'h88 && tf1_ack) ncon[7] = 1'b0;
        if (n0.ovf) ncon[5] = 1'b1;
        if (tf1_set) ncon[7] = 1'b1;
        m_tcon = ncon;
        if (wa == 'h89) m_tmod = wd;
        m_th[0] = n0.th; m_tl[0] = n0.tl; m_th[1] = n1.th; m_tl[1] = n1.tl;
    endtask

    function automatic logic [7:0] model_read(logic [7:0] a);
        case (a)
            8'h88: return m_tcon;
            8'h89: return m_tmod;
            8'h8A: return 8'(m_tl[0]);
            8'h8B: return 8'(m_tl[1]);
            8'h8C: return 8'(m_th[0]);
            8'h8D: return 8'(m_th[1]);
            default: return 8'h00;
        endcase
    endfunction

    // One clock: the model consumes the inputs held across the coming edge.
    task automatic cycle();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr_bus.sfr_addr = a; sfr_bus.sfr_wdata = d; sfr_bus.sfr_we = 1'b1;
        cycle();
        sfr_bus.sfr_we = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
        sfr_bus.sfr_addr = a;
        #1;
        d = sfr_bus.sfr_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_ps(input int target);
        int guard = 0;
        while (m_ps != target && guard < 2 * PS) begin cycle(); guard++; end
    endtask

    task automatic t0_pulse();
        t0_pin = 1'b0;
        repeat (2 * PS) cycle();
        t0_pin = 1'b1;
        repeat (2 * PS) cycle();
    endtask

    task automatic test_reset();
        logic [7:0] addrs [6];
        logic [7:0] d;
        addrs = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D};
        do_reset();
        foreach (addrs[i]) sfr_write(addrs[i], 8'hFF);
        sfr_read(8'h89, d);
        n_checks++;
        if (d !== 8'hFF) begin n_errors++; $display("FAIL reset_pre_tmod: got %h want ff", d); end
        do_reset();
        foreach (addrs[i]) begin
            sfr_read(addrs[i], d);
            n_checks++;
            if (d !== 8'h00) begin n_errors++; $display("FAIL reset_sfr_%h: got %h want 00", addrs[i], d); end
            n_checks++;
            if (sfr_bus.sfr_hit !== 1'b1) begin n_errors++; $display("FAIL hit_%h: got %b want 1", addrs[i], sfr_bus.sfr_hit); end
        end
        n_checks++;
        if ({irq_tf1, irq_tf0} !== 2'b00) begin n_errors++; $display("FAIL reset_irq: got %b want 00", {irq_tf1, irq_tf0}); end
        sfr_read(8'h8E, d);
        n_checks++;
        if (d !== 8'h00 || sfr_bus.sfr_hit !== 1'b0) begin
            n_errors++; $display("FAIL unmapped: got data %h hit %b want 00/0", d, sfr_bus.sfr_hit);
        end
    endtask

    task automatic test_mode1();
        int n = 0;
        logic [7:0] d;
        do_reset();
        sfr_write(8'h89, 8'h01);
        sfr_write(8'h8C, 8'hFF);
        sfr_write(8'h8A, 8'hFE);
        sfr_write(8'h88, 8'h10);
        while (irq_tf0 !== 1'b1 && n < 3 * PS) begin cycle(); n++; end
        n_checks++;
        if (n < PS + 1 || n > 2 * PS) begin n_errors++; $display("FAIL mode1_latency: got %0d clocks want %0d..%0d", n, PS + 1, 2 * PS); end
        sfr_read(8'h8C, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL mode1_th0: got %h want 00", d); end
        sfr_read(8'h8A, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL mode1_tl0: got %h want 00", d); end
        tf0_ack = 1'b1;
        cycle();
        tf0_ack = 1'b0;
        n_checks++;
        if (irq_tf0 !== 1'b0) begin n_errors++; $display("FAIL mode1_ack: got %b want 0", irq_tf0); end
    endtask

    task automatic test_mode2_reload();
        int n = 0;
        logic [7:0] d;
        do_reset();
        sfr_write(8'h89, 8'h20);
        sfr_write(8'h8D, 8'hF0);
        sfr_write(8'h8B, 8'hFF);
        sfr_write(8'h88, 8'h40);
        while (irq_tf1 !== 1'b1 && n < 2 * PS) begin cycle(); n++; end
        n_checks++;
        if (irq_tf1 !== 1'b1) begin n_errors++; $display("FAIL mode2_first_tf1: got %b want 1", irq_tf1); end
        sfr_read(8'h8B, d);
        n_checks++;
        if (d !== 8'hF0) begin n_errors++; $display("FAIL mode2_reload: got %h want f0", d); end
        tf1_ack = 1'b1;
        cycle();
        tf1_ack = 1'b0;
        n = 1;
        n_checks++;
        if (irq_tf1 !== 1'b0) begin n_errors++; $display("FAIL mode2_ack: got %b want 0", irq_tf1); end
        while (irq_tf1 !== 1'b1 && n < 20 * PS) begin cycle(); n++; end
        n_checks++;
        if (n !== 16 * PS) begin n_errors++; $display("FAIL mode2_period: got %0d clocks want %0d", n, 16 * PS); end
    endtask

    task automatic test_gate_counter();
        logic [7:0] d;
        do_reset();
        int0_n = 1'b0;
        sfr_write(8'h89, 8'h0D);
        sfr_write(8'h88, 8'h10);
        repeat (3) t0_pulse();
        sfr_read(8'h8A, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL gate_closed_tl0: got %h want 00", d); end
        int0_n = 1'b1;
        repeat (4) cycle();
        repeat (3) t0_pulse();
        sfr_read(8'h8A, d);
        n_checks++;
        if (d !== 8'h03) begin n_errors++; $display("FAIL counter_tl0: got %h want 03", d); end
        sfr_read(8'h8C, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL counter_th0: got %h want 00", d); end
    endtask

    task automatic test_collisions();
        logic [7:0] d;
        do_reset();
        sfr_write(8'h89, 8'h01);
        sfr_write(8'h8C, 8'h12);
        sfr_write(8'h8A, 8'hFF);
        wait_ps(PS - 2);
        sfr_write(8'h88, 8'h10);
        sfr_write(8'h8A, 8'h55);
        sfr_read(8'h8A, d);
        n_checks++;
        if (d !== 8'h55) begin n_errors++; $display("FAIL coll_tl0_write: got %h want 55", d); end
        sfr_read(8'h8C, d);
        n_checks++;
        if (d !== 8'h12) begin n_errors++; $display("FAIL coll_carry_dropped: got %h want 12", d); end
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h8C, 8'hFF);
        sfr_write(8'h8A, 8'hFF);
        wait_ps(PS - 2);
        sfr_write(8'h88, 8'h10);
        sfr_write(8'h88, 8'h10);
        n_checks++;
        if (irq_tf0 !== 1'b1) begin n_errors++; $display("FAIL coll_set_wins: got %b want 1", irq_tf0); end
        sfr_read(8'h8C, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL coll_wrap_th0: got %h want 00", d); end
        sfr_write(8'h88, 8'h10);
        n_checks++;
        if (irq_tf0 !== 1'b0) begin n_errors++; $display("FAIL tcon_clear: got %b want 0", irq_tf0); end
    endtask

    task automatic test_mode3();
        int n = 0;
        logic [7:0] d;
        do_reset();
        sfr_write(8'h89, 8'h03);
        sfr_write(8'h8C, 8'hFF);
        sfr_write(8'h88, 8'h50);
        sfr_read(8'h8A, d);
        while (d === 8'h00 && n < 2 * PS) begin cycle(); n++; sfr_read(8'h8A, d); end
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL mode3_tl0: got %h want 01", d); end
        sfr_read(8'h8C, d);
        n_checks++;
        if (d !== (MODE3 ? 8'h00 : 8'hFF)) begin n_errors++; $display("FAIL mode3_th0: got %h want %h", d, MODE3 ? 8'h00 : 8'hFF); end
        n_checks++;
        if (irq_tf1 !== MODE3) begin n_errors++; $display("FAIL mode3_tf1: got %b want %b", irq_tf1, MODE3); end
        n_checks++;
        if (irq_tf0 !== 1'b0) begin n_errors++; $display("FAIL mode3_tf0: got %b want 0", irq_tf0); end
        sfr_read(8'h8B, d);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL mode3_tl1: got %h want 01", d); end
    endtask

    task automatic test_random(input int cycles);
        logic [7:0] addrs [7];
        logic [7:0] a, d, exp;
        addrs = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h87};
        do_reset();
        int0_n = 1'($urandom_range(0, 1));
        int1_n = 1'($urandom_range(0, 1));
        repeat (4) cycle();
        for (int i = 0; i < cycles; i++) begin
            a = addrs[$urandom_range(0, 6)];
            sfr_bus.sfr_we = 1'b0;
            if ($urandom_range(0, 7) == 0 && a != 8'h87) begin
                case ($urandom_range(0, 3))
                    0: d = 8'hFF;
                    1: d = 8'hFE;
                    2: d = 8'h00;
                    default: d = 8'($urandom);
                endcase
                if (a == 8'h89) d = d & 8'hBB;
                sfr_bus.sfr_we = 1'b1;
                sfr_bus.sfr_wdata = d;
            end
            tf0_ack = ($urandom_range(0, 15) == 0);
            tf1_ack = ($urandom_range(0, 15) == 0);
            sfr_read(a, d);
            exp = model_read(a);
            n_checks++;
            if (d !== exp) begin n_errors++; $display("FAIL rand_sfr_%h@%0d: got %h want %h", a, i, d, exp); end
            n_checks++;
            if ({irq_tf1, irq_tf0} !== {m_tcon[7], m_tcon[5]}) begin
                n_errors++; $display("FAIL rand_irq@%0d: got %b want %b", i, {irq_tf1, irq_tf0}, {m_tcon[7], m_tcon[5]});
            end
            cycle();
        end
        sfr_bus.sfr_we = 1'b0;
        tf0_ack = 1'b0;
        tf1_ack = 1'b0;
    endtask

    initial begin
        sfr_bus.sfr_addr = 8'h00;
        sfr_bus.sfr_we = 1'b0;
        sfr_bus.sfr_wdata = 8'h00;
        m_tmod = 8'h00;
        m_tcon = 8'h00;
        @(negedge clock);
        test_reset();
        test_mode1();
        test_mode2_reload();
        test_gate_counter();
        test_collisions();
        test_mode3();
        test_random(3000);
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
